// File: rtl/gb_stream_tx.sv
// Pixel streamer: accepts a W x H frame from upstream and emits it as an AXI4-Stream through a small skid FIFO.
// Build option GB_TX_PATTERN_EN replaces the upstream source with an internal (x+y) test-pattern generator.
module gb_stream_tx #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [8:0]  frame_w,
  input  logic [9:0]  frame_h,
  input  logic [7:0]  pix_in,
  input  logic        pix_in_valid,
  output logic        pix_in_ready,
  output logic [7:0]  arg_1_TDATA,
  output logic        arg_1_TVALID,
  output logic        arg_1_TLAST,
  input  logic        arg_1_TREADY,
  output logic        busy,
  output logic        done,
  output logic [18:0] pix_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [8:0]    w_r, x_r;
  logic [9:0]    h_r, y_r;
  logic [18:0]   total_r, acc_cnt_r, pix_cnt_r;
  logic [8:0]    fifo_r [FIFO_DEPTH];
  logic [8:0]    fifo_s [FIFO_DEPTH];
  logic [CW-1:0] cnt_r, cnt_s, wr_idx_s;
  logic          valid_r, busy_r, done_r;
  logic          start_ok_s, can_accept_s, accept_s, pop_s, last_hs_s, last_flag_s;
  logic [7:0]    pix_s;

  assign start_ok_s   = (state_r == IDLE) && start && (frame_w != 9'd0) && (frame_h != 10'd0);
  assign can_accept_s = (state_r == RUN) && (cnt_r != CW'(FIFO_DEPTH)) && (acc_cnt_r < total_r);
  assign last_flag_s  = (x_r == (w_r - 9'd1)) && (y_r == (h_r - 10'd1));
  assign pop_s        = valid_r && arg_1_TREADY;
  assign last_hs_s    = pop_s && fifo_r[0][0];

`ifdef GB_TX_PATTERN_EN
  logic [9:0] xy_sum_s;
  logic       unused_s;
  assign xy_sum_s     = {1'b0, x_r} + y_r;
  assign pix_s        = xy_sum_s[7:0];
  assign accept_s     = can_accept_s;
  assign pix_in_ready = 1'b0;
  assign unused_s     = ^{pix_in, pix_in_valid, xy_sum_s[9:8]};
`else
  assign pix_s        = pix_in;
  assign accept_s     = can_accept_s && pix_in_valid;
  assign pix_in_ready = can_accept_s;
`endif

  // Frame control next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) state_s = RUN;
        else            state_s = IDLE;
      end
      RUN: begin
        if (accept_s && (acc_cnt_r == (total_r - 19'd1))) state_s = FLUSH;
        else                                              state_s = RUN;
      end
      FLUSH: begin
        if (last_hs_s) state_s = IDLE;
        else           state_s = FLUSH;
      end
      default: state_s = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_s;
  end

  // Shift-register FIFO: entry 0 is always the head, vacated slots fill with zero
  always_comb begin
    wr_idx_s = pop_s ? (cnt_r - CW'(1)) : cnt_r;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (accept_s && (CW'(i) == wr_idx_s)) fifo_s[i] = {pix_s, last_flag_s};
      else if (pop_s)                       fifo_s[i] = (i < FIFO_DEPTH - 1) ? fifo_r[(i + 1) % FIFO_DEPTH] : 9'd0;
      else                                  fifo_s[i] = fifo_r[i];
    end
    case ({accept_s, pop_s})
      2'b10:   cnt_s = cnt_r + CW'(1);
      2'b01:   cnt_s = cnt_r - CW'(1);
      default: cnt_s = cnt_r;
    endcase
  end

  // FIFO storage, occupancy and registered stream valid
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= 9'd0;
      cnt_r   <= CW'(0);
      valid_r <= 1'b0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_r[i] <= fifo_s[i];
      cnt_r   <= cnt_s;
      valid_r <= (cnt_s != CW'(0));
    end
  end

  // Frame geometry latch and raster position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      w_r       <= 9'd0;
      h_r       <= 10'd0;
      total_r   <= 19'd0;
      x_r       <= 9'd0;
      y_r       <= 10'd0;
      acc_cnt_r <= 19'd0;
    end else if (start_ok_s) begin
      w_r       <= frame_w;
      h_r       <= frame_h;
      total_r   <= 19'(frame_w) * 19'(frame_h);
      x_r       <= 9'd0;
      y_r       <= 10'd0;
      acc_cnt_r <= 19'd0;
    end else if (accept_s) begin
      acc_cnt_r <= acc_cnt_r + 19'd1;
      if (x_r == (w_r - 9'd1)) begin
        x_r <= 9'd0;
        y_r <= y_r + 10'd1;
      end else begin
        x_r <= x_r + 9'd1;
      end
    end
  end

  // Status outputs: beat counter, busy and end-of-frame pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt_r <= 19'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      if (start_ok_s)                          pix_cnt_r <= 19'd0;
      else if (pop_s && (pix_cnt_r != 19'h7FFFF)) pix_cnt_r <= pix_cnt_r + 19'd1;
      busy_r <= (state_s != IDLE);
      done_r <= (state_r == FLUSH) && last_hs_s;
    end
  end

  assign arg_1_TDATA  = fifo_r[0][8:1];
  assign arg_1_TLAST  = fifo_r[0][0];
  assign arg_1_TVALID = valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign pix_cnt      = pix_cnt_r;

endmodule

// File: tb/tb_gb_stream_tx.sv
// Self-checking bench for gb_stream_tx: per-cycle monitor against a frame model (expected pixel array,
// beat index, TLAST position, done timing) plus directed scenario checks.
module tb_gb_stream_tx;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst, start, pix_in_valid, pix_in_ready;
  logic [8:0]  frame_w;
  logic [9:0]  frame_h;
  logic [7:0]  pix_in, arg_1_TDATA;
  logic        arg_1_TVALID, arg_1_TLAST, arg_1_TREADY, busy, done;
  logic [18:0] pix_cnt;

  always #5 clk = ~clk;

  gb_stream_tx #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_w(frame_w), .frame_h(frame_h),
    .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
    .arg_1_TDATA(arg_1_TDATA), .arg_1_TVALID(arg_1_TVALID), .arg_1_TLAST(arg_1_TLAST),
    .arg_1_TREADY(arg_1_TREADY), .busy(busy), .done(done), .pix_cnt(pix_cnt)
  );

  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] seq [1024];
  logic [7:0] got [1024];
  int total = 0, beat = 0, lasts = 0, k = 0, acc = 0;
  int first_acc = -1, first_valid = -1, first_beat = -1, last_beat = -1;
  bit mon_en = 0, feed_en = 0, frame_done = 0, done_pend = 0, prev_stall = 0;
  bit tready_rand = 0, valid_rand = 0, tready_val = 0;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Upstream source and downstream sink
  initial begin : feeder
    bit hs;
    pix_in = 8'd0; pix_in_valid = 1'b0; arg_1_TREADY = 1'b0;
    forever begin
      @(negedge clk);
      hs = pix_in_valid && pix_in_ready;
      if (hs) begin
        if (first_acc < 0) first_acc = cyc;
        acc++;
      end
      @(posedge clk);
      #1;
      if (hs) k++;
      pix_in       = seq[k % 1024];
      pix_in_valid = feed_en && (k < total) && (valid_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
      arg_1_TREADY = tready_rand ? ($urandom_range(0, 1) == 1) : tready_val;
    end
  end

  // Output monitor compared with the frame model every cycle
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("pix_cnt", 32'(pix_cnt), beat);
      check("done", 32'(done), 32'(done_pend));
      if (done_pend) begin
        frame_done = 1;
        check("busy_after_done", 32'(busy), 0);
      end
      done_pend = 0;
`ifdef GB_TX_PATTERN_EN
      check("ready_held0", 32'(pix_in_ready), 0);
`endif
      if (prev_stall) begin
        check("stall_valid", 32'(arg_1_TVALID), 1);
        check("stall_data", 32'(arg_1_TDATA), 32'(prev_data));
        check("stall_last", 32'(arg_1_TLAST), 32'(prev_last));
      end
      if (arg_1_TVALID && first_valid < 0) first_valid = cyc;
      if (arg_1_TVALID && arg_1_TREADY) begin
        if (beat < total) begin
          check("tdata", 32'(arg_1_TDATA), 32'(seq[beat]));
          check("tlast", 32'(arg_1_TLAST), 32'(beat == total - 1));
        end else begin
          check("extra_beat", beat, total);
        end
        got[beat % 1024] = arg_1_TDATA;
        if (arg_1_TLAST) lasts++;
        if (beat == total - 1) done_pend = 1;
        if (beat == 0) first_beat = cyc;
        last_beat = cyc;
        beat++;
      end
      prev_stall = arg_1_TVALID && !arg_1_TREADY;
      prev_data  = arg_1_TDATA;
      prev_last  = arg_1_TLAST;
    end
  end

  task automatic start_frame(input int w, input int h);
    @(posedge clk);
    #1;
    total = w * h;
    for (int i = 0; i < 1024; i++) begin
`ifdef GB_TX_PATTERN_EN
      seq[i] = 8'((i % w) + (i / w));
`else
      seq[i] = 8'($urandom);
`endif
    end
    k = 0; acc = 0; first_acc = -1;
    frame_w = 9'(w); frame_h = 10'(h); start = 1'b1; feed_en = 1;
    @(posedge clk);
    #1;
    start = 1'b0;
    frame_w = 9'($urandom); frame_h = 10'($urandom);
    beat = 0; lasts = 0; frame_done = 0; done_pend = 0; prev_stall = 0;
    first_valid = -1; first_beat = -1; last_beat = -1;
    mon_en = 1;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) break;
    end
    check(name, 32'(frame_done), 1);
    feed_en = 0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 0;
  endtask

  initial begin
    int exp_pat [6] = '{0, 1, 2, 1, 2, 3};
    rst = 1'b1; start = 1'b0; frame_w = 9'd0; frame_h = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", 32'(arg_1_TVALID), 0);
    check("rst_tlast", 32'(arg_1_TLAST), 0);
    check("rst_tdata", 32'(arg_1_TDATA), 0);
    check("rst_ready", 32'(pix_in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_pix_cnt", 32'(pix_cnt), 0);
    rst = 1'b0;

`ifdef GB_TX_PATTERN_EN
    tready_val = 1; valid_rand = 1;
    start_frame(3, 2);
    wait_done(200, "pat_timeout");
    for (int i = 0; i < 6; i++) check("pat_data", 32'(got[i]), exp_pat[i]);
    check("pat_beats", beat, 6);
    check("pat_lasts", lasts, 1);
    check("pat_pix_cnt", 32'(pix_cnt), 6);
`else
    // 4x2 streaming at full rate, with a start pulse mid-frame that must be ignored
    tready_val = 1; valid_rand = 0; tready_rand = 0;
    start_frame(4, 2);
    @(posedge clk); #1; start = 1'b1; frame_w = 9'd1; frame_h = 10'd1;
    @(posedge clk); #1; start = 1'b0;
    wait_done(100, "t1_timeout");
    check("t1_beats", beat, 8);
    check("t1_lasts", lasts, 1);
    check("t1_consecutive", last_beat - first_beat, 7);
    check("t1_latency", first_valid - first_acc, 1);
    check("t1_pix_cnt", 32'(pix_cnt), 8);
    check("t1_busy_idle", 32'(busy), 0);

    // 3x1 with downstream stalled: FIFO fills, head holds
    tready_val = 0;
    start_frame(3, 1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (arg_1_TVALID) break;
    end
    check("t2_valid_seen", 32'(arg_1_TVALID), 1);
    repeat (5) @(posedge clk);
    #1;
    check("t2_ready_low", 32'(pix_in_ready), 0);
    check("t2_accepted", acc, (D < 3) ? D : 3);
    tready_val = 1;
    wait_done(100, "t2_timeout");
    check("t2_beats", beat, 3);
    check("t2_lasts", lasts, 1);

    // start with zero width is ignored
    @(posedge clk); #1;
    feed_en = 0; frame_w = 9'd0; frame_h = 10'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("t3_busy", 32'(busy), 0);
      check("t3_tvalid", 32'(arg_1_TVALID), 0);
      check("t3_done", 32'(done), 0);
    end

    // 8x8 aborted by reset after 20 beats, then a clean 2x1 frame
    tready_rand = 1; valid_rand = 1;
    start_frame(8, 8);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (beat >= 20) break;
    end
    check("t4_beat20", beat, 20);
    mon_en = 0; feed_en = 0; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t4_rst_tvalid", 32'(arg_1_TVALID), 0);
    check("t4_rst_tlast", 32'(arg_1_TLAST), 0);
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_done", 32'(done), 0);
    check("t4_rst_pix_cnt", 32'(pix_cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0; tready_rand = 0; tready_val = 1; valid_rand = 0;
    start_frame(2, 1);
    wait_done(100, "t4b_timeout");
    check("t4b_beats", beat, 2);
    check("t4b_lasts", lasts, 1);

    // long random-handshake frame
    tready_rand = 1; valid_rand = 1;
    start_frame(488, 2);
    wait_done(20000, "t5_timeout");
    check("t5_beats", beat, 976);
    check("t5_lasts", lasts, 1);
    check("t5_pix_cnt", 32'(pix_cnt), 976);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
